mem_port_arbiter: RTL

Parametrised N-port arbiter between the cache/DMA memory clients (program cache, data cache, video/DMA port) and the single SDRAM controller request port. It generalises the fixed three-port p1/p2/p3 hookup to NPORTS clients and selects fixed-priority or round-robin arbitration at elaboration time. Each granted transaction is one burst of BURST_LEN words, with word offsets forwarded back to the owning client.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SDRAM controller request port between NPORTS
// burst clients (program cache, data cache, video/DMA, ...). One transaction
// is one burst of BURST_LEN words. The controller's word strobe, offset and
// read data are fanned back out to whichever port currently owns the grant.
// Arbitration is fixed priority (port 0 highest) or round-robin, chosen by
// RR_MODE when the design is elaborated.
module mem_port_arbiter #(
    parameter int NPORTS    = 3,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 4,
    parameter int RR_MODE   = 0,
    parameter int OFF_W     = $clog2(BURST_LEN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        p_req,
    input  logic [NPORTS-1:0]        p_wren,
    input  logic [NPORTS*ADDR_W-1:0] p_address,
    input  logic [NPORTS*DATA_W-1:0] p_to_mem,
    output logic [NPORTS-1:0]        p_ready,
    output logic [OFF_W-1:0]         p_offset,
    output logic [DATA_W-1:0]        from_mem,
    output logic                     ctl_req,
    output logic                     ctl_wren,
    output logic [ADDR_W-1:0]        ctl_address,
    output logic [DATA_W-1:0]        ctl_to_mem,
    input  logic                     ctl_ready,
    input  logic [OFF_W-1:0]         ctl_offset,
    input  logic [DATA_W-1:0]        ctl_from_mem,
    output logic [NPORTS-1:0]        grant,
    output logic                     busy
);

    localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NPORTS - 1);

    // IDLE waits for a request, ISSUE holds ctl_req until the controller
    // accepts, BURST counts the remaining words, DONE is the one-cycle gap
    // in which the previous owner cannot immediately re-win.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BURST,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NPORTS-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic               wren_q, wren_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [OFF_W-1:0]   count_q, count_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    // Winner selection among the current requests. Only consumed in IDLE,
    // so the previous owner is naturally excluded during DONE.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        if (RR_MODE != 0) begin
            // Search starts just after the last owner and wraps around, so
            // a port that was just served goes to the back of the line.
            for (int k = 1; k <= NPORTS; k++) begin
                cand = int'(last_grant_q) + k;
                if (cand >= NPORTS) begin
                    cand = cand - NPORTS;
                end
                cand_idx = IDX_W'(cand);
                if (!win_found && p_req[cand_idx]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
        end else begin
            // Lowest index wins.
            for (int i = 0; i < NPORTS; i++) begin
                cand_idx = IDX_W'(i);
                if (!win_found && p_req[cand_idx]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx;
                end
            end
        end
    end

    // Next-state logic: grant capture, burst word counting and release.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wren_d       = wren_q;
        addr_d       = addr_q;
        count_d      = count_q;
        ctl_req      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    // Latch the winner's command so the controller sees a
                    // stable address/direction even if the port lets go.
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                    wren_d           = p_wren[win_idx];
                    addr_d           = p_address[win_idx*ADDR_W +: ADDR_W];
                    count_d          = '0;
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ctl_req = 1'b1;
                if (ctl_ready) begin
                    // The acceptance strobe is also the first data word.
                    count_d = OFF_W'(1);
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (ctl_ready) begin
                    if (count_q == LAST_WORD) begin
                        // Drop the grant now so no strobe can leak to the
                        // old owner during the DONE gap.
                        grant_d = '0;
                        count_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                last_grant_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset is shared with the SDRAM controller.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_grant_q <= LAST_PORT;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
        end
    end

    // Write data mux from the owning port; zero when nobody holds a grant.
    always_comb begin
        ctl_to_mem = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_q[i]) begin
                ctl_to_mem = ctl_to_mem | p_to_mem[i*DATA_W +: DATA_W];
            end
        end
    end

    assign p_ready     = grant_q & {NPORTS{ctl_ready}};
    assign p_offset    = ctl_offset;
    assign from_mem    = ctl_from_mem;
    assign ctl_wren    = wren_q;
    assign ctl_address = addr_q;
    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
